// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: default widths, FSM state
// encoding and the counter-width helper.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;
    localparam int unsigned UART_CNT_W  = 16;

    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StLoad,
        StStart,
        StWait,
        StGap
    } sched_state_e;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned count_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/uart_sched_timer.sv
// Loadable down-counter with a zero flag; holds at zero rather than wrapping.
module uart_sched_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q, count_d;

    assign zero = (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && !zero) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Transmit scheduler: pops one byte from the TX FIFO, hands it to the transmitter,
// waits for frame completion with a timeout, then inserts an optional idle gap.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W         = UART_DATA_W,
    parameter int unsigned GAP_CYCLES     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned CNT_W          = UART_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              cts_n,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_data_rd,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              err_timeout,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  frames_sent
);

    localparam int unsigned TMO_W = count_width(TIMEOUT_CYCLES);
    localparam int unsigned GAP_W = count_width(GAP_CYCLES);
    // Timers are loaded with N-1 so the zero flag marks the Nth cycle in the state.
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    sched_state_e state_q, state_d;

    logic              tmo_load, tmo_dec, tmo_zero;
    logic              gap_load, gap_dec, gap_zero;
    logic              frame_done, timeout;
    logic [DATA_W-1:0] tx_data_q;
    logic              err_timeout_q;
    logic [CNT_W-1:0]  frames_sent_q;

    always_comb begin
        state_d    = state_q;
        fifo_rd_en = 1'b0;
        tx_start   = 1'b0;
        tmo_load   = 1'b0;
        tmo_dec    = 1'b0;
        gap_load   = 1'b0;
        gap_dec    = 1'b0;
        frame_done = 1'b0;
        timeout    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable && !cts_n && !fifo_empty) begin
                    state_d = StPop;
                end
            end
            StPop: begin
                fifo_rd_en = 1'b1;
                state_d    = StLoad;
            end
            StLoad: begin
                state_d = StStart;
            end
            StStart: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    tmo_load = 1'b1;
                    state_d  = StWait;
                end
            end
            StWait: begin
                tmo_dec = 1'b1;
                // A completion arriving on the last permitted cycle beats the timeout.
                if (tx_done) begin
                    frame_done = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        gap_load = 1'b1;
                        state_d  = StGap;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (tmo_zero) begin
                    timeout = 1'b1;
                    state_d = StIdle;
                end
            end
            StGap: begin
                if (gap_zero) begin
                    state_d = StIdle;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            tx_data_q     <= '0;
            err_timeout_q <= 1'b0;
            frames_sent_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StLoad) begin
                tx_data_q <= fifo_data_rd;
            end
            if (timeout) begin
                err_timeout_q <= 1'b1;
            end else if (err_clr) begin
                err_timeout_q <= 1'b0;
            end
            if (frame_done) begin
                frames_sent_q <= frames_sent_q + CNT_W'(1);
            end
        end
    end

    uart_sched_timer #(
        .W(TMO_W)
    ) u_tmo_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (tmo_load),
        .load_val(TMO_LOAD),
        .dec     (tmo_dec),
        .zero    (tmo_zero)
    );

    uart_sched_timer #(
        .W(GAP_W)
    ) u_gap_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (gap_load),
        .load_val(GAP_LOAD),
        .dec     (gap_dec),
        .zero    (gap_zero)
    );

    assign busy        = (state_q != StIdle);
    assign tx_data     = tx_data_q;
    assign err_timeout = err_timeout_q;
    assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with GAP_CYCLES=4 and TIMEOUT_CYCLES=10; the FIFO
// is a small model and the transmitter handshake is driven step by step.
module tb_uart_tx_sched;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int          FRAME  = 8;
    // Start-to-start spacing: frame + gap + IDLE/POP/LOAD/START.
    localparam int          SPACING = FRAME + 4 + 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic              cts_n;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_data_rd;
    logic              tx_busy;
    logic              tx_done;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              busy;
    logic              err_timeout;
    logic              err_clr;
    logic [CNT_W-1:0]  frames_sent;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DATA_W-1:0] mem [8];
    int wr_cnt = 0;
    int rd_cnt = 0;

    uart_tx_sched #(
        .DATA_W        (DATA_W),
        .GAP_CYCLES    (4),
        .TIMEOUT_CYCLES(10),
        .CNT_W         (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .cts_n       (cts_n),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_data_rd(fifo_data_rd),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_clr     (err_clr),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign fifo_empty = (wr_cnt == rd_cnt);

    // FIFO model: registered read, data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (fifo_rd_en === 1'b1) begin
            if (fifo_empty) begin
                errors++;
                $error("FAIL pop_while_empty: observed rd_en=1 empty=1 expected no pop");
            end
            fifo_data_rd <= mem[rd_cnt[2:0]];
            rd_cnt       <= rd_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [DATA_W-1:0] b);
        mem[wr_cnt[2:0]] = b;
        wr_cnt++;
    endtask

    task automatic wait_start(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            if (tx_start === 1'b1) begin
                at = cyc;
                break;
            end
            @(negedge clk);
        end
        check("start_seen", 32'(at >= 0), 32'd1);
    endtask

    // Called at the tx_start sample point; tx_done lands FRAME cycles after tx_start.
    task automatic finish_frame();
        repeat (FRAME) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    initial begin
        int s1, s2, s3;
        reset_n      = 1'b0;
        enable       = 1'b0;
        cts_n        = 1'b1;
        tx_busy      = 1'b0;
        tx_done      = 1'b0;
        err_clr      = 1'b0;
        fifo_data_rd = '0;
        repeat (2) @(negedge clk);
        check("rst_frames", frames_sent, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_timeout, 0);
        check("rst_start", tx_start, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_data", tx_data, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single byte
        enable = 1'b1;
        cts_n  = 1'b0;
        push(8'hA5);
        @(negedge clk);
        check("t1_rd_en", fifo_rd_en, 1);
        check("t1_busy", busy, 1);
        @(negedge clk);
        check("t1_rd_en_pulse", fifo_rd_en, 0);
        wait_start(10, s1);
        check("t1_data", tx_data, 8'hA5);
        finish_frame();
        repeat (3) @(negedge clk);
        check("t1_in_gap", busy, 1);
        @(negedge clk);
        check("t1_idle", busy, 0);
        check("t1_frames", frames_sent, 1);

        // Three bytes back to back, FIFO order and spacing
        push(8'h11);
        push(8'h22);
        push(8'h33);
        wait_start(10, s1);
        check("t2_data0", tx_data, 8'h11);
        finish_frame();
        wait_start(30, s2);
        check("t2_data1", tx_data, 8'h22);
        check("t2_space1", s2 - s1, SPACING);
        finish_frame();
        wait_start(30, s3);
        check("t2_data2", tx_data, 8'h33);
        check("t2_space2", s3 - s2, SPACING);
        finish_frame();
        repeat (4) @(negedge clk);
        check("t2_frames", frames_sent, 4);
        check("t2_empty", fifo_empty, 1);
        check("t2_idle", busy, 0);

        // CTS raised mid-frame: current frame and gap finish, next byte waits
        push(8'h44);
        push(8'h55);
        wait_start(10, s1);
        check("t3_data0", tx_data, 8'h44);
        cts_n = 1'b1;
        finish_frame();
        repeat (10) @(negedge clk);
        check("t3_held_idle", busy, 0);
        check("t3_not_popped", fifo_empty, 0);
        check("t3_frames_mid", frames_sent, 5);
        cts_n = 1'b0;
        wait_start(10, s1);
        check("t3_data1", tx_data, 8'h55);
        finish_frame();
        repeat (4) @(negedge clk);
        check("t3_frames", frames_sent, 6);

        // Timeout: no tx_done
        push(8'h66);
        wait_start(10, s1);
        repeat (10) @(negedge clk);
        check("t4_no_err_yet", err_timeout, 0);
        check("t4_still_wait", busy, 1);
        @(negedge clk);
        check("t4_err", err_timeout, 1);
        check("t4_idle", busy, 0);
        check("t4_frames", frames_sent, 6);
        repeat (3) @(negedge clk);
        check("t4_sticky", err_timeout, 1);

        // Second timeout with err_clr in the same cycle: the set wins
        push(8'h88);
        wait_start(10, s1);
        repeat (10) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t4_clr_collide", err_timeout, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t4_clr", err_timeout, 0);

        // tx_done on the last permitted cycle beats the timeout
        push(8'h77);
        wait_start(10, s1);
        repeat (10) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("t4_edge_err", err_timeout, 0);
        check("t4_edge_frames", frames_sent, 7);
        check("t4_edge_gap", busy, 1);
        repeat (4) @(negedge clk);

        // Transmitter busy holds START for 5 cycles
        tx_busy = 1'b1;
        push(8'h99);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("t5_no_start", tx_start, 0);
            check("t5_busy", busy, 1);
            @(negedge clk);
        end
        tx_busy = 1'b0;
        #1;
        check("t5_start", tx_start, 1);
        check("t5_data", tx_data, 8'h99);
        finish_frame();
        repeat (4) @(negedge clk);
        check("t5_frames", frames_sent, 8);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        @(negedge clk);
        check("t5_stray_done", frames_sent, 8);
        check("t5_stray_busy", busy, 0);
        check("t5_stray_err", err_timeout, 0);

        // Asynchronous reset during WAIT
        push(8'hAA);
        wait_start(10, s1);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_data", tx_data, 0);
        check("t6_frames", frames_sent, 0);
        check("t6_start", tx_start, 0);
        check("t6_rd_en", fifo_rd_en, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("t6_idle_after", busy, 0);
        push(8'hBB);
        wait_start(10, s1);
        check("t6_data_after", tx_data, 8'hBB);
        finish_frame();
        repeat (4) @(negedge clk);
        check("t6_frames_after", frames_sent, 1);
        check("t6_idle_end", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
